// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the entrada_debouncer slice.
package debounce_pkg;

    typedef enum logic {DB_STABLE, DB_COUNTING} db_state_t;

    // Counter must hold DEBOUNCE_CYCLES itself without wrapping.
    function automatic int db_cnt_width(int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/entrada_debouncer_if.sv
// Bus between the raw switch inputs and the debounced entrada consumer.
// rise/fall exist only when DEBOUNCE_EDGE_PULSE_EN is defined.
interface entrada_debouncer_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] entrada;
    logic             changed;
    logic             busy;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    modport master (output raw_in, input entrada, changed, busy, rise, fall);
    modport slave  (input raw_in, output entrada, changed, busy, rise, fall);
`else
    modport master (output raw_in, input entrada, changed, busy);
    modport slave  (input raw_in, output entrada, changed, busy);
`endif
endinterface

// File: rtl/debounce_bit.sv
// One debounce channel: synchroniser chain, STABLE/COUNTING FSM and counter.
// toggle is asserted in the cycle whose edge flips level.
module debounce_bit
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic toggle,
    output logic counting
);
    localparam int            CW       = db_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_params
            $error("debounce_bit: DEBOUNCE_CYCLES must be >=1 and SYNC_STAGES >=2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q;

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q  <= '0;
            state_q <= DB_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_q ^ toggle;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        toggle  = 1'b0;
        case (state_q)
            DB_STABLE: begin
                if (s != level_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        toggle = 1'b1;
                    end else begin
                        state_d = DB_COUNTING;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            DB_COUNTING: begin
                if (s == level_q) begin
                    // Bounce back to the old level: drop all progress.
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    toggle  = 1'b1;
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    assign level    = level_q;
    assign counting = (state_q == DB_COUNTING);

endmodule

// File: rtl/entrada_debouncer.sv
// Debounced input bank feeding flip_flop_D.entrada; one debounce_bit per channel.
// Define DEBOUNCE_EDGE_PULSE_EN to add registered per-bit rise/fall pulses.
module entrada_debouncer
    import debounce_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2
) (
    input logic                clk,
    input logic                reset_n,
    entrada_debouncer_if.slave bus
);
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] counting;
    logic             changed_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (bus.raw_in[i]),
            .level   (level[i]),
            .toggle  (toggle[i]),
            .counting(counting[i])
        );
    end

    // Registered on the same edge as the level flip, so it lines up with the new entrada.
    always_ff @(posedge clk) begin
        if (!reset_n) changed_q <= 1'b0;
        else          changed_q <= |toggle;
    end

    assign bus.entrada = level;
    assign bus.changed = changed_q;
    assign bus.busy    = |counting;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= toggle & ~level;
            fall_q <= toggle & level;
        end
    end

    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
`endif

endmodule

// File: tb/tb_entrada_debouncer.sv
// Directed bench for entrada_debouncer (defaults WIDTH=2, DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// rise/fall are compared only when DEBOUNCE_EDGE_PULSE_EN is defined.
module tb_entrada_debouncer;

    typedef struct {
        logic       rst_n;
        logic [1:0] raw;
        logic [1:0] ent;
        logic       ch;
        logic       busy;
        logic [1:0] rise;
        logic [1:0] fall;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    entrada_debouncer_if #(.WIDTH(2)) bus ();

    entrada_debouncer #(
        .WIDTH(2), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive away from the active edge, then sample 1 time unit after it.
    task automatic step(input logic rst, input logic [1:0] raw);
        @(negedge clk);
        reset_n    = rst;
        bus.raw_in = raw;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rst, input logic [1:0] raw, input logic [1:0] ent,
                       input logic ch, input logic busy,
                       input logic [1:0] rise, input logic [1:0] fall);
        vec_t v;
        v.rst_n = rst; v.raw = raw; v.ent = ent; v.ch = ch;
        v.busy = busy; v.rise = rise; v.fall = fall;
        vecs.push_back(v);
    endtask

    // raw held for edges 0..6: busy edges 2..4, new entrada with one pulse at edge 5.
    task automatic add_accept(input logic [1:0] raw, input logic [1:0] old_ent);
        for (int k = 0; k < 7; k++) begin
            add(1'b1, raw, (k >= 5) ? raw : old_ent, (k == 5), (k >= 2 && k <= 4),
                (k == 5) ? (raw & ~old_ent) : 2'b00,
                (k == 5) ? (old_ent & ~raw) : 2'b00);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] ent, input logic ch,
                                 input logic busy, input logic [1:0] rise, input logic [1:0] fall);
        check({tag, ".entrada"}, 32'(bus.entrada), 32'(ent));
        check({tag, ".changed"}, 32'(bus.changed), 32'(ch));
        check({tag, ".busy"},    32'(bus.busy),    32'(busy));
`ifdef DEBOUNCE_EDGE_PULSE_EN
        check({tag, ".rise"},    32'(bus.rise),    32'(rise));
        check({tag, ".fall"},    32'(bus.fall),    32'(fall));
`else
        if (rise !== fall) begin end
`endif
    endtask

    initial begin
        logic [9:0] bounce_busy;
        reset_n    = 1'b0;
        bus.raw_in = 2'b11;

        // Reset with raw=11, then clear raw while still in reset and release.
        add(1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        add(1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        add(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        add(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        add(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        // Glitch: raw[1] high for 3 cycles then low; never accepted.
        for (int k = 0; k < 7; k++)
            add(1'b1, (k < 3) ? 2'b10 : 2'b00, 2'b00, 1'b0, (k >= 2 && k <= 4), 2'b00, 2'b00);
        add_accept(2'b01, 2'b00);   // single channel rise
        add_accept(2'b00, 2'b01);   // back to 00
        add_accept(2'b11, 2'b00);   // both channels together
        add_accept(2'b10, 2'b11);   // bit 0 falls only

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].raw);
            check_outputs($sformatf("vec%0d", i), vecs[i].ent, vecs[i].ch,
                          vecs[i].busy, vecs[i].rise, vecs[i].fall);
        end

        // Reset in the middle of a count discards it; full latency restarts.
        for (int k = 0; k < 4; k++) step(1'b1, 2'b11);
        check("midreset.pre_busy", 32'(bus.busy), 32'd1);
        check("midreset.pre_ent",  32'(bus.entrada), 32'(2'b10));
        step(1'b0, 2'b11);
        check_outputs("midreset.rst", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 2'b11);
            check_outputs($sformatf("midreset.k%0d", k), (k >= 5) ? 2'b11 : 2'b00, (k == 5),
                          (k >= 2 && k <= 4), (k == 5) ? 2'b11 : 2'b00, 2'b00);
        end

        // Bounce back for one cycle mid-count: the count restarts from zero.
        bounce_busy = 10'b0111011100;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, (k == 3) ? 2'b11 : 2'b10);
            check_outputs($sformatf("bounce.k%0d", k), (k == 9) ? 2'b10 : 2'b11, (k == 9),
                          bounce_busy[k], 2'b00, (k == 9) ? 2'b01 : 2'b00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
